// File: rtl/axil_led_regs.sv
// axil_led_regs: AXI4-Lite register block with ID, scratch, LED control and a free-running cycle counter.
module axil_led_regs #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] ID_VALUE   = 32'h5053_0001,
  parameter int          LED_WIDTH  = 4
) (
  input  logic                  zynq_clk,
  input  logic                  zynq_resetn,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [LED_WIDTH-1:0]  led_out
);
  localparam logic [1:0] RESP_OK     = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [31:0]           scratch_q, scratch_d;
  logic [LED_WIDTH-1:0]  led_q, led_d;
  logic [31:0]           cnt_q, cnt_d;
  logic                  aw_hs, w_hs, ar_hs, do_wr, wr_map, rd_map;
  logic [1:0]            wr_idx, rd_idx;
  logic [31:0]           mask, led_ext, rd_val;
  logic                  unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, awaddr_q[1:0], s_axi_araddr[1:0]};
  always_comb begin
    aw_hs     = s_axi_awvalid & awready_q;
    w_hs      = s_axi_wvalid & wready_q;
    ar_hs     = s_axi_arvalid & arready_q;
    do_wr     = aw_got_q & w_got_q & ~bvalid_q;
    wr_map    = (awaddr_q[ADDR_WIDTH-1:5] == '0) & ~awaddr_q[4];
    wr_idx    = awaddr_q[3:2];
    mask      = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};
    led_ext   = 32'(led_q);
    bvalid_d  = do_wr | (bvalid_q & ~s_axi_bready);
    bresp_d   = do_wr ? (wr_map ? RESP_OK : RESP_SLVERR) : bresp_q;
    aw_got_d  = ~do_wr & (aw_got_q | aw_hs);
    w_got_d   = ~do_wr & (w_got_q | w_hs);
    awready_d = ~aw_got_d & ~bvalid_d;
    wready_d  = ~w_got_d & ~bvalid_d;
    awaddr_d  = aw_hs ? s_axi_awaddr : awaddr_q;
    wdata_d   = w_hs ? s_axi_wdata : wdata_q;
    wstrb_d   = w_hs ? s_axi_wstrb : wstrb_q;
    scratch_d = (do_wr & wr_map & (wr_idx == 2'd1)) ? ((wdata_q & mask) | (scratch_q & ~mask)) : scratch_q;
    led_d     = (do_wr & wr_map & (wr_idx == 2'd2)) ? LED_WIDTH'((wdata_q & mask) | (led_ext & ~mask)) : led_q;
    cnt_d     = (do_wr & wr_map & (wr_idx == 2'd3)) ? 32'd0 : cnt_q + 32'd1;
    rd_map    = (s_axi_araddr[ADDR_WIDTH-1:5] == '0) & ~s_axi_araddr[4];
    rd_idx    = s_axi_araddr[3:2];
    rd_val    = (rd_idx == 2'd0) ? ID_VALUE : (rd_idx == 2'd1) ? scratch_q : (rd_idx == 2'd2) ? led_ext : cnt_q;
    rvalid_d  = ar_hs | (rvalid_q & ~s_axi_rready);
    rdata_d   = ar_hs ? (rd_map ? rd_val : 32'd0) : rdata_q;
    rresp_d   = ar_hs ? (rd_map ? RESP_OK : RESP_SLVERR) : rresp_q;
    arready_d = ~rvalid_d;
  end
  always_ff @(posedge zynq_clk or negedge zynq_resetn) begin
    if (!zynq_resetn) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OK;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OK;
      scratch_q <= '0;
      led_q     <= '0;
      cnt_q     <= '0;
    end else begin
      awready_q <= awready_d;
      wready_q  <= wready_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      scratch_q <= scratch_d;
      led_q     <= led_d;
      cnt_q     <= cnt_d;
    end
  end
  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign led_out       = led_q;
endmodule

// File: tb/tb_axil_led_regs.sv
// tb_axil_led_regs: directed AXI4-Lite bench; expected responses are queued at issue and checked by a monitor.
module tb_axil_led_regs;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [11:0] s_axi_awaddr = '0, s_axi_araddr = '0;
  logic [2:0]  s_axi_awprot = '0, s_axi_arprot = '0;
  logic        s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_arvalid = 1'b0;
  logic        s_axi_bready = 1'b1, s_axi_rready = 1'b1;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic [31:0] s_axi_rdata;
  logic [3:0]  led_out;
  localparam logic [31:0] ID = 32'h5053_0001;
  typedef struct {logic [31:0] d; logic [1:0] r; int k;} rexp_t;
  rexp_t       rq[$];
  logic [1:0]  bq[$];
  logic [31:0] cnt_first = '0;
  int          total = 0, bad = 0;
  axil_led_regs dut (
    .zynq_clk(clk), .zynq_resetn(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .led_out(led_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    logic [1:0] be;
    rexp_t      re;
    if (rst_n && s_axi_bvalid && s_axi_bready) begin
      if (bq.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected: got bresp %b with nothing queued", s_axi_bresp);
      end else begin
        be = bq.pop_front();
        chk("bresp", 32'(s_axi_bresp), 32'(be));
      end
    end
    if (rst_n && s_axi_rvalid && s_axi_rready) begin
      if (rq.size() == 0) begin
        total++; bad++;
        $display("FAIL r_unexpected: got rdata %h with nothing queued", s_axi_rdata);
      end else begin
        re = rq.pop_front();
        chk("rresp", 32'(s_axi_rresp), 32'(re.r));
        if (re.k == 0) chk("rdata", s_axi_rdata, re.d);
        else if (re.k == 1) cnt_first = s_axi_rdata;
        else chk("cnt_delta", s_axi_rdata - cnt_first, re.d);
      end
    end
  end
  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int awdly, input int wdly, input int hold, input logic [1:0] er);
    logic ha, hw;
    int   na, nw, n;
    bq.push_back(er);
    if (hold > 0) s_axi_bready = 1'b0;
    fork
      begin
        na = 0;
        if (awdly > 0) begin repeat (awdly) @(posedge clk); #1; end
        s_axi_awaddr = a; s_axi_awvalid = 1'b1;
        do begin @(negedge clk); ha = s_axi_awready; @(posedge clk); na++; end while (!ha && na < 50);
        #1 s_axi_awvalid = 1'b0;
      end
      begin
        nw = 0;
        if (wdly > 0) begin repeat (wdly) @(posedge clk); #1; end
        s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
        do begin @(negedge clk); hw = s_axi_wready; @(posedge clk); nw++; end while (!hw && nw < 50);
        #1 s_axi_wvalid = 1'b0;
      end
    join
    chk("aw_hs", 32'(ha), 1);
    chk("w_hs", 32'(hw), 1);
    chk("bvalid_early", 32'(s_axi_bvalid), 0);
    chk("awready_captured", 32'(s_axi_awready), 0);
    chk("wready_captured", 32'(s_axi_wready), 0);
    @(posedge clk); #1;
    chk("bvalid_rise", 32'(s_axi_bvalid), 1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("bvalid_hold", 32'(s_axi_bvalid), 1);
      chk("bresp_hold", 32'(s_axi_bresp), 32'(er));
      chk("readys_hold", 32'({s_axi_awready, s_axi_wready}), 0);
    end
    s_axi_bready = 1'b1;
    n = 0;
    while (s_axi_bvalid && n < 20) begin @(posedge clk); #1; n++; end
    chk("b_done", 32'(s_axi_bvalid), 0);
    chk("readys_back", 32'({s_axi_awready, s_axi_wready}), 2'b11);
  endtask
  task automatic axi_read(input logic [11:0] a, input int k, input logic [31:0] ed, input logic [1:0] er);
    logic h;
    int   n;
    rq.push_back('{d: ed, r: er, k: k});
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); h = s_axi_arready; @(posedge clk); n++; end while (!h && n < 50);
    #1 s_axi_arvalid = 1'b0;
    chk("ar_hs", 32'(h), 1);
    chk("rvalid_next", 32'(s_axi_rvalid), 1);
    chk("arready_busy", 32'(s_axi_arready), 0);
    n = 0;
    while (s_axi_rvalid && n < 20) begin @(posedge clk); #1; n++; end
    chk("r_done", 32'(s_axi_rvalid), 0);
    chk("arready_back", 32'(s_axi_arready), 1);
  endtask
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_readys", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 0);
    chk("rst_valids", 32'({s_axi_bvalid, s_axi_rvalid}), 0);
    chk("rst_rdata", s_axi_rdata, 0);
    chk("rst_resps", 32'({s_axi_bresp, s_axi_rresp}), 0);
    chk("rst_led", 32'(led_out), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("readys_after_rst", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 3'b111);
    axi_read(12'h000, 0, ID, 2'b00);
    axi_write(12'h004, 32'hA5A5_A5A5, 4'b0101, 0, 3, 5, 2'b00);
    axi_read(12'h004, 0, 32'h00A5_00A5, 2'b00);
    axi_write(12'h007, 32'h1234_5678, 4'b1000, 0, 0, 0, 2'b00);
    axi_read(12'h006, 0, 32'h12A5_00A5, 2'b00);
    axi_write(12'h008, 32'hFFFF_FFF9, 4'b1111, 2, 0, 0, 2'b00);
    chk("led_9", 32'(led_out), 4'h9);
    axi_read(12'h008, 0, 32'h0000_0009, 2'b00);
    axi_write(12'h008, 32'h0000_0000, 4'b1110, 0, 0, 0, 2'b00);
    chk("led_strb_skip", 32'(led_out), 4'h9);
    axi_write(12'h000, 32'h0000_0000, 4'b1111, 0, 0, 0, 2'b00);
    axi_read(12'h000, 0, ID, 2'b00);
    axi_write(12'h00C, 32'h0000_0000, 4'b0000, 0, 0, 0, 2'b00);
    axi_read(12'h00C, 1, 32'h0, 2'b00);
    repeat (8) @(posedge clk);
    #1;
    axi_read(12'h00C, 2, 32'd10, 2'b00);
    axi_write(12'h014, 32'hFFFF_FFFF, 4'b1111, 0, 0, 0, 2'b10);
    axi_read(12'h014, 0, 32'h0, 2'b10);
    axi_write(12'h104, 32'hFFFF_FFFF, 4'b1111, 0, 0, 0, 2'b10);
    axi_read(12'h104, 0, 32'h0, 2'b10);
    axi_read(12'h004, 0, 32'h12A5_00A5, 2'b00);
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    s_axi_awaddr = 12'h004; s_axi_wdata = 32'hDEAD_BEEF; s_axi_wstrb = 4'hF;
    s_axi_araddr = 12'h000;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_bvalid", 32'(s_axi_bvalid), 1);
    chk("pre_rst_rvalid", 32'(s_axi_rvalid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valids", 32'({s_axi_bvalid, s_axi_rvalid}), 0);
    chk("mid_rst_readys", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 0);
    chk("mid_rst_rdata", s_axi_rdata, 0);
    chk("mid_rst_led", 32'(led_out), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_led", 32'(led_out), 0);
    chk("post_rst_bvalid", 32'(s_axi_bvalid), 0);
    axi_read(12'h004, 0, 32'h0, 2'b00);
    n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 20) begin @(posedge clk); n++; end
    chk("bq_drained", 32'(bq.size()), 0);
    chk("rq_drained", 32'(rq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
